// File: rtl/cache_miss_ctrl_pkg.sv
// Shared definitions for the cache miss controller: FSM state encoding and default address width.
// The address width default matches the address port of cache_direct.
package cache_miss_ctrl_pkg;

  localparam int ADDR_W_DEF = 11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_CHECK  = 3'd2,
    S_MEM    = 3'd3,
    S_FILL   = 3'd4,
    S_RESP   = 3'd5
  } state_t;

endpackage

// File: rtl/cache_miss_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats a same-cycle increment.
// Count updates one cycle after the inc/clr strobe and never wraps.
module cache_miss_ctrl_sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cache_miss_ctrl.sv
// Single-outstanding CPU access sequencer: cache lookup, memory refill with timeout, line fill, status.
// Hit completes 3 cycles after acceptance, miss 5+N; requests arriving while busy are dropped, not queued.
module cache_miss_ctrl
  import cache_miss_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_req,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  output logic              o_cpu_ready,
  output logic              o_cpu_hit,
  output logic              o_cpu_err,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_cache_addr,
  output logic              o_cache_lookup,
  input  logic              i_cache_hit,
  output logic              o_cache_fill,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic              i_stats_clr,
  output logic [CNT_W-1:0]  o_hit_count,
  output logic [CNT_W-1:0]  o_miss_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [WAIT_W-1:0] r_wait;
  logic              r_hit;
  logic              r_err;
  logic              w_timeout;
  logic              w_hit_inc;
  logic              w_miss_inc;

  // Timeout fires in the MEM cycle that brings the wait count up to MEM_TIMEOUT.
  assign w_timeout = (r_wait == WAIT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    o_busy         = 1'b1;
    o_cache_lookup = 1'b0;
    o_cache_fill   = 1'b0;
    o_mem_req      = 1'b0;
    o_cpu_ready    = 1'b0;
    w_hit_inc      = 1'b0;
    w_miss_inc     = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_cpu_req) w_state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        o_cache_lookup = 1'b1;
        w_state_nxt    = S_CHECK;
      end
      S_CHECK: begin
        if (i_cache_hit) begin
          w_hit_inc   = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_miss_inc  = 1'b1;
          w_state_nxt = S_MEM;
        end
      end
      S_MEM: begin
        o_mem_req = 1'b1;
        if (i_mem_ack)      w_state_nxt = S_FILL;
        else if (w_timeout) w_state_nxt = S_RESP;
      end
      S_FILL: begin
        o_cache_fill = 1'b1;
        w_state_nxt  = S_RESP;
      end
      S_RESP: begin
        o_cpu_ready = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        o_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Status flags are only ever set on entry to RESP, so they read 0 outside the ready pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr <= '0;
      r_wait <= '0;
      r_hit  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && i_cpu_req) r_addr <= i_cpu_addr;
      if (r_state == S_CHECK)    r_wait <= '0;
      else if (r_state == S_MEM) r_wait <= r_wait + WAIT_W'(1);
      r_hit <= w_hit_inc;
      r_err <= (r_state == S_MEM) && !i_mem_ack && w_timeout;
    end
  end

  assign o_cpu_hit    = r_hit;
  assign o_cpu_err    = r_err;
  assign o_cache_addr = r_addr;
  assign o_mem_addr   = r_addr;

  cache_miss_ctrl_sat_counter #(.W(CNT_W)) u_hit_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_stats_clr),
    .i_inc   (w_hit_inc),
    .o_count (o_hit_count)
  );

  cache_miss_ctrl_sat_counter #(.W(CNT_W)) u_miss_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_stats_clr),
    .i_inc   (w_miss_inc),
    .o_count (o_miss_count)
  );

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: 16-line direct-mapped cache model, delay-programmable memory,
// transaction-level expectation model checked every cycle, plus directed literal checks.
module tb_cache_miss_ctrl;

  localparam int AW  = 11;
  localparam int TMO = 4;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          cpu_req   = 1'b0;
  logic [AW-1:0] cpu_addr  = '0;
  logic          cache_hit = 1'b0;
  logic          mem_ack   = 1'b0;
  logic          stats_clr = 1'b0;

  logic          cpu_ready, cpu_hit, cpu_err, busy, cache_lookup, cache_fill, mem_req;
  logic [AW-1:0] cache_addr, mem_addr;
  logic [15:0]   hit_count, miss_count;
  logic          s_ready, s_hit, s_err, s_busy, s_lookup, s_fill, s_mreq;
  logic [AW-1:0] s_caddr, s_maddr;
  logic [1:0]    s_hit_count, s_miss_count;

  cache_miss_ctrl #(.ADDR_W(AW), .CNT_W(16), .MEM_TIMEOUT(TMO)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr),
    .o_cpu_ready(cpu_ready), .o_cpu_hit(cpu_hit), .o_cpu_err(cpu_err), .o_busy(busy),
    .o_cache_addr(cache_addr), .o_cache_lookup(cache_lookup), .i_cache_hit(cache_hit),
    .o_cache_fill(cache_fill), .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_ack(mem_ack),
    .i_stats_clr(stats_clr), .o_hit_count(hit_count), .o_miss_count(miss_count)
  );

  cache_miss_ctrl #(.ADDR_W(AW), .CNT_W(2), .MEM_TIMEOUT(TMO)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr),
    .o_cpu_ready(s_ready), .o_cpu_hit(s_hit), .o_cpu_err(s_err), .o_busy(s_busy),
    .o_cache_addr(s_caddr), .o_cache_lookup(s_lookup), .i_cache_hit(cache_hit),
    .o_cache_fill(s_fill), .o_mem_req(s_mreq), .o_mem_addr(s_maddr), .i_mem_ack(mem_ack),
    .i_stats_clr(stats_clr), .o_hit_count(s_hit_count), .o_miss_count(s_miss_count)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  // Environment: cache tag store and memory responder.
  bit          c_vld [16];
  bit [AW-5:0] c_tag [16];
  logic        look_res = 1'b0;
  int          mem_delay = -1;
  int          mw = 0;

  always @(negedge clk) begin
    look_res = cache_lookup && c_vld[cache_addr[3:0]] && (c_tag[cache_addr[3:0]] == cache_addr[AW-1:4]);
    if (cache_fill) begin
      c_vld[cache_addr[3:0]] = 1'b1;
      c_tag[cache_addr[3:0]] = cache_addr[AW-1:4];
    end
  end

  always @(posedge clk) begin
    #1;
    cache_hit = look_res;
    if (mem_req) begin
      mem_ack = (mem_delay >= 0) && (mw == mem_delay);
      mw++;
    end else begin
      mem_ack = 1'b0;
      mw = 0;
    end
  end

  // Expected transaction: accepted at edge acc_a, ready at relative cycle e_len.
  int            txn_id = 0, cancel_id = 0, acc_a = 0, e_len = 0, e_memc = 0;
  bit            e_hit = 0, e_err = 0, e_fill = 0;
  logic [AW-1:0] e_addr = '0;
  int            raw_hit = 0, raw_miss = 0;
  bit            clr_prev = 0;
  int            n_mreq = 0, n_fill = 0, n_ready = 0;
  logic [AW-1:0] last_maddr = '0;

  always @(negedge clk) begin
    int rel;
    bit act, x_ready;
    if (!rst_n) begin
      raw_hit   = 0;
      raw_miss  = 0;
      clr_prev  = 0;
      cancel_id = txn_id;
    end else begin
      rel = cyc - acc_a + 1;
      act = (txn_id != cancel_id) && (rel >= 1) && (rel <= e_len);
      if (clr_prev) begin
        raw_hit  = 0;
        raw_miss = 0;
      end else begin
        if (act && e_hit && rel == e_len) raw_hit++;
        if (act && !e_hit && rel == 3)    raw_miss++;
      end
      clr_prev = stats_clr;
      x_ready  = act && (rel == e_len);
      chk("busy",         busy,         act);
      chk("cache_lookup", cache_lookup, act && rel == 1);
      chk("mem_req",      mem_req,      act && !e_hit && rel >= 3 && rel < 3 + e_memc);
      chk("cache_fill",   cache_fill,   act && e_fill && rel == e_len - 1);
      chk("cpu_ready",    cpu_ready,    x_ready);
      chk("sat_cpu_ready", s_ready,     x_ready);
      chk("hit_count",    hit_count,    sat(raw_hit, 16));
      chk("miss_count",   miss_count,   sat(raw_miss, 16));
      chk("sat_hit_count",  s_hit_count,  sat(raw_hit, 2));
      chk("sat_miss_count", s_miss_count, sat(raw_miss, 2));
      if (x_ready) begin
        chk("cpu_hit", cpu_hit, e_hit);
        chk("cpu_err", cpu_err, e_err);
      end
      if (act) begin
        chk("cache_addr", cache_addr, e_addr);
        chk("mem_addr",   mem_addr,   e_addr);
      end
      if (mem_req) begin
        n_mreq++;
        last_maddr = mem_addr;
      end
      if (cache_fill) n_fill++;
      if (cpu_ready)  n_ready++;
    end
  end

  task automatic start_txn(input logic [AW-1:0] a, input int delay);
    bit h;
    h = c_vld[a[3:0]] && (c_tag[a[3:0]] == a[AW-1:4]);
    e_addr    = a;
    e_hit     = h;
    mem_delay = delay;
    if (h) begin
      e_len = 3; e_memc = 0; e_err = 0; e_fill = 0;
    end else if (delay >= 0 && delay < TMO) begin
      e_len = 5 + delay; e_memc = delay + 1; e_err = 0; e_fill = 1;
    end else begin
      e_len = 3 + TMO; e_memc = TMO; e_err = 1; e_fill = 0;
    end
    acc_a = cyc + 1;
    txn_id++;
    cpu_addr = a;
    cpu_req  = 1'b1;
  endtask

  int   g_rel;
  logic g_hit, g_err;

  // inj_rel / clr_rel of 0 mean none; otherwise drive a stray request or stats_clr in that cycle.
  task automatic access(input logic [AW-1:0] a, input int delay, input int inj_rel, input int clr_rel);
    int rel;
    bit done;
    done  = 0;
    g_rel = -1;
    g_hit = 1'bx;
    g_err = 1'bx;
    start_txn(a, delay);
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk); #1;
      rel       = cyc - acc_a + 1;
      cpu_req   = (rel == inj_rel);
      if (rel == inj_rel) cpu_addr = 11'd768;
      stats_clr = (rel == clr_rel);
      if (cpu_ready) begin
        done  = 1;
        g_rel = rel;
        g_hit = cpu_hit;
        g_err = cpu_err;
      end
    end
    if (!done) chk("ready_timeout", 0, 1);
    @(posedge clk); #1;
    cpu_req   = 1'b0;
    stats_clr = 1'b0;
  endtask

  initial begin
    int m0, f0, r0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_cache_addr", cache_addr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_lookup", cache_lookup, 0);
    chk("rst_fill", cache_fill, 0);
    chk("rst_ready", cpu_ready, 0);
    chk("rst_hit_err", {cpu_hit, cpu_err}, 0);
    chk("rst_counts", {hit_count, miss_count}, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Cold miss with ack after 2 MEM cycles.
    m0 = n_mreq; f0 = n_fill;
    access(11'd34, 2, 0, 0);
    chk("s1_ready_cycle", g_rel, 7);
    chk("s1_hit_err", {g_hit, g_err}, 2'b00);
    chk("s1_mem_req_cycles", n_mreq - m0, 3);
    chk("s1_fills", n_fill - f0, 1);
    chk("s1_mem_addr", last_maddr, 34);
    chk("s1_miss_count", miss_count, 1);

    // Repeat hits.
    m0 = n_mreq;
    access(11'd34, 0, 0, 0);
    chk("s2_ready_cycle", g_rel, 3);
    chk("s2_hit", g_hit, 1);
    chk("s2_no_mem_req", n_mreq - m0, 0);
    chk("s2_hit_count", hit_count, 1);

    // Conflict trace on index 0; last ack lands on the timeout cycle.
    f0 = n_fill;
    access(11'd512, 0, 0, 0);
    chk("s3a_ready_cycle", g_rel, 5);
    access(11'd528, 1, 0, 0);
    chk("s3b_ready_cycle", g_rel, 6);
    access(11'd512, 3, 0, 0);
    chk("s3c_ready_cycle", g_rel, 8);
    chk("s3c_hit_err", {g_hit, g_err}, 2'b00);
    chk("s3_fills", n_fill - f0, 3);
    chk("s3_miss_count", miss_count, 4);
    chk("s3_sat_miss_count", s_miss_count, 3);

    // Memory never acks.
    m0 = n_mreq; f0 = n_fill;
    access(11'd200, -1, 0, 0);
    chk("s4_ready_cycle", g_rel, 7);
    chk("s4_err", {g_hit, g_err}, 2'b01);
    chk("s4_mem_req_cycles", n_mreq - m0, 4);
    chk("s4_no_fill", n_fill - f0, 0);
    chk("s4_miss_count", miss_count, 5);

    // Stray request while busy on a miss.
    r0 = n_ready;
    access(11'd300, 1, 4, 0);
    chk("s5_ready_cycle", g_rel, 6);
    repeat (3) begin @(posedge clk); #1; end
    chk("s5_one_ready", n_ready - r0, 1);
    chk("s5_idle", busy, 0);
    chk("s5_cache_addr", cache_addr, 300);

    // stats_clr coincident with a hit increment.
    access(11'd34, 0, 0, 2);
    chk("s6_clr_hit", g_hit, 1);
    chk("s6_clr_hit_count", hit_count, 0);
    chk("s6_clr_miss_count", miss_count, 0);

    for (int i = 0; i < 5; i++) access(11'd34, 0, 0, 0);
    chk("s6_hit_count5", hit_count, 5);
    chk("s6_sat_hit_count", s_hit_count, 3);

    // Async reset in the middle of MEM.
    r0 = n_ready; f0 = n_fill;
    start_txn(11'd600, -1);
    repeat (4) begin @(posedge clk); #1; cpu_req = 1'b0; end
    chk("s6_in_mem", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_mem_req", mem_req, 0);
    chk("s6_rst_cache_addr", cache_addr, 0);
    chk("s6_rst_mem_addr", mem_addr, 0);
    chk("s6_rst_counts", {hit_count, miss_count}, 0);
    chk("s6_rst_sat_counts", {s_hit_count, s_miss_count}, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("s6_rst_no_ready", n_ready - r0, 0);
    chk("s6_rst_no_fill", n_fill - f0, 0);
    chk("s6_rst_idle", busy, 0);

    access(11'd34, 0, 0, 0);
    chk("s6_post_rst_ready", g_rel, 3);
    chk("s6_post_rst_hit_count", hit_count, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
